// File: rtl/wb_bram_ctrl.sv
// Wishbone-classic slave front-end for the user-area block RAM: programmable wait,
// one BRAM access per bus cycle, single-cycle ack, and master-abort handling.
module wb_bram_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DELAYS = 10
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_dat_i,
    input  logic [31:0]       wbs_adr_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              ram_en_o,
    output logic [3:0]        ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i,
    output logic              busy_o
);

    localparam int CNT_W = (DELAYS < 1) ? 1 : $clog2(DELAYS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAYS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we;
    logic [3:0]       r_sel;
    logic             w_req;
    logic             w_accept;
    logic             w_ack_nxt;
    logic [31:0]      w_dat_nxt;
    logic             w_en_nxt;
    logic [3:0]       w_we_nxt;
    logic             w_busy_nxt;
    logic             w_unused;

    assign w_req    = wbs_cyc_i & wbs_stb_i;
    assign w_accept = (r_state == S_IDLE) & w_req;
    // Byte-offset and alias bits of the address are deliberately dropped.
    assign w_unused = ^{wbs_adr_i[31:ADDR_W+2], wbs_adr_i[1:0]};

    // State register, wait counter and request capture
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= {CNT_W{1'b0}};
            r_we        <= 1'b0;
            r_sel       <= 4'b0000;
            ram_addr_o  <= {ADDR_W{1'b0}};
            ram_wdata_o <= 32'h0000_0000;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt       <= {CNT_W{1'b0}};
                r_we        <= wbs_we_i;
                r_sel       <= wbs_sel_i;
                ram_addr_o  <= wbs_adr_i[ADDR_W+1:2];
                ram_wdata_o <= wbs_dat_i;
            end else if (w_state_nxt == S_WAIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // Next-state logic; a dropped cyc abandons the transfer from any busy state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!wbs_cyc_i) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_ACCESS;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_ACCESS: begin
                if (!wbs_cyc_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        w_en_nxt   = (r_state == S_WAIT) && (w_state_nxt == S_ACCESS);
        w_we_nxt   = 4'b0000;
        w_ack_nxt  = (r_state == S_RESP) && wbs_cyc_i;
        w_dat_nxt  = 32'h0000_0000;
        w_busy_nxt = (w_state_nxt != S_IDLE);
        if (w_en_nxt && r_we) begin
            w_we_nxt = r_sel;
        end else begin
            w_we_nxt = 4'b0000;
        end
        if (w_ack_nxt && !r_we) begin
            w_dat_nxt = ram_rdata_i;
        end else begin
            w_dat_nxt = 32'h0000_0000;
        end
    end

    // Output registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'h0000_0000;
            ram_en_o  <= 1'b0;
            ram_we_o  <= 4'b0000;
            busy_o    <= 1'b0;
        end else begin
            wbs_ack_o <= w_ack_nxt;
            wbs_dat_o <= w_dat_nxt;
            ram_en_o  <= w_en_nxt;
            ram_we_o  <= w_we_nxt;
            busy_o    <= w_busy_nxt;
        end
    end

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// Scoreboard bench for wb_bram_ctrl: one instance with DELAYS=10, one with DELAYS=0,
// each backed by a behavioural BRAM model.
module tb_wb_bram_ctrl;

    typedef struct {
        int          d;
        int          cyc;
        logic [3:0]  we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        bit          chk_wdata;
    } en_t;

    typedef struct {
        int          d;
        int          cyc;
        logic [31:0] data;
    } ack_t;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic        cyc   [2];
    logic        stb   [2];
    logic        we    [2];
    logic [3:0]  sel   [2];
    logic [31:0] dati  [2];
    logic [31:0] adr   [2];
    logic        ack   [2];
    logic [31:0] dato  [2];
    logic        en    [2];
    logic [3:0]  rwe   [2];
    logic [9:0]  raddr [2];
    logic [31:0] rwdata[2];
    logic [31:0] rrdata[2];
    logic        busy  [2];
    logic [31:0] mem   [2][1024];

    int   cyc_cnt = 0;
    int   n_cmp   = 0;
    int   n_fail  = 0;
    en_t  en_q[$];
    ack_t ack_q[$];
    en_t  mon_e;
    ack_t mon_a;

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    wb_bram_ctrl #(.ADDR_W(10), .DELAYS(10)) u_dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst[0]),
        .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]), .wbs_we_i(we[0]), .wbs_sel_i(sel[0]),
        .wbs_dat_i(dati[0]), .wbs_adr_i(adr[0]), .wbs_ack_o(ack[0]), .wbs_dat_o(dato[0]),
        .ram_en_o(en[0]), .ram_we_o(rwe[0]), .ram_addr_o(raddr[0]), .ram_wdata_o(rwdata[0]),
        .ram_rdata_i(rrdata[0]), .busy_o(busy[0])
    );

    wb_bram_ctrl #(.ADDR_W(10), .DELAYS(0)) u_dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst[1]),
        .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]), .wbs_we_i(we[1]), .wbs_sel_i(sel[1]),
        .wbs_dat_i(dati[1]), .wbs_adr_i(adr[1]), .wbs_ack_o(ack[1]), .wbs_dat_o(dato[1]),
        .ram_en_o(en[1]), .ram_we_o(rwe[1]), .ram_addr_o(raddr[1]), .ram_wdata_o(rwdata[1]),
        .ram_rdata_i(rrdata[1]), .busy_o(busy[1])
    );

    // Single-port read-first BRAM models, data valid one cycle after the enable
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (en[d]) begin
                rrdata[d] <= mem[d][raddr[d]];
                for (int b = 0; b < 4; b++) begin
                    if (rwe[d][b]) mem[d][raddr[d]][8*b +: 8] <= rwdata[d][8*b +: 8];
                end
            end
        end
    end

    // Monitor: every enable pulse and ack must match the head of its queue
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (en[d] === 1'b1) begin
                n_cmp++;
                if (en_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL ram_en dut%0d: unexpected pulse at cycle %0d addr=%0d we=%h, required none",
                             d, cyc_cnt, raddr[d], rwe[d]);
                end else begin
                    mon_e = en_q.pop_front();
                    if (mon_e.d != d || mon_e.cyc != cyc_cnt || rwe[d] !== mon_e.we ||
                        raddr[d] !== mon_e.addr || (mon_e.chk_wdata && rwdata[d] !== mon_e.wdata)) begin
                        n_fail++;
                        $display("FAIL ram_en dut%0d: got cyc=%0d we=%h addr=%0d wdata=%h, required dut%0d cyc=%0d we=%h addr=%0d wdata=%h",
                                 d, cyc_cnt, rwe[d], raddr[d], rwdata[d],
                                 mon_e.d, mon_e.cyc, mon_e.we, mon_e.addr, mon_e.wdata);
                    end
                end
            end
            if (ack[d] === 1'b1) begin
                n_cmp++;
                if (ack_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL ack dut%0d: unexpected ack at cycle %0d dat=%h, required none",
                             d, cyc_cnt, dato[d]);
                end else begin
                    mon_a = ack_q.pop_front();
                    if (mon_a.d != d || mon_a.cyc != cyc_cnt || dato[d] !== mon_a.data) begin
                        n_fail++;
                        $display("FAIL ack dut%0d: got cyc=%0d dat=%h, required dut%0d cyc=%0d dat=%h",
                                 d, cyc_cnt, dato[d], mon_a.d, mon_a.cyc, mon_a.data);
                    end
                end
            end
        end
    end

    function automatic int dly_of(int d);
        return (d == 0) ? 10 : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk_idle(int d, string tag);
        chk({tag, "_ack"},   {31'd0, ack[d]},  32'd0);
        chk({tag, "_dato"},  dato[d],          32'd0);
        chk({tag, "_en"},    {31'd0, en[d]},   32'd0);
        chk({tag, "_we"},    {28'd0, rwe[d]},  32'd0);
        chk({tag, "_addr"},  {22'd0, raddr[d]}, 32'd0);
        chk({tag, "_wdata"}, rwdata[d],        32'd0);
        chk({tag, "_busy"},  {31'd0, busy[d]}, 32'd0);
    endtask

    // Drive a request; the DUT samples it on the next edge (cycle t)
    task automatic issue(int d, bit w, logic [3:0] s, logic [31:0] a, logic [31:0] dt,
                         bit push_en, bit push_ack, logic [31:0] exp_rd);
        int t;
        en_t  e;
        ack_t k;
        t = cyc_cnt + 1;
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; sel[d] = s; adr[d] = a; dati[d] = dt;
        if (push_en) begin
            e.d = d; e.cyc = t + 1 + dly_of(d); e.we = w ? s : 4'b0000;
            e.addr = a[11:2]; e.wdata = dt; e.chk_wdata = w;
            en_q.push_back(e);
        end
        if (push_ack) begin
            k.d = d; k.cyc = t + 3 + dly_of(d); k.data = w ? 32'h0 : exp_rd;
            ack_q.push_back(k);
        end
    endtask

    // Wait for ack while scrambling the held bus inputs, then release the bus
    task automatic wait_ack(int d, string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            dati[d] = $urandom; adr[d] = $urandom;
            sel[d]  = 4'($urandom); we[d] = 1'($urandom);
            if (ack[d] === 1'b1) begin
                seen = 1'b1;
                cyc[d] = 1'b0; stb[d] = 1'b0;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            cyc[d] = 1'b0; stb[d] = 1'b0;
            $display("FAIL %s: got no ack within 40 cycles, required an ack", nm);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
            sel[d] = 4'h0; dati[d] = 32'h0; adr[d] = 32'h0;
        end
        repeat (3) tick();
        chk_idle(0, "reset0");
        chk_idle(1, "reset1");
        rst[0] = 1'b0; rst[1] = 1'b0;
        tick();

        // Full write then read back through DUT0 (DELAYS=10)
        issue(0, 1'b1, 4'hF, 32'h3800_0010, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0);
        wait_ack(0, "wr_word4");
        issue(0, 1'b0, 4'h0, 32'h3800_0010, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        wait_ack(0, "rd_word4");
        tick();
        chk("ack_clears", {31'd0, ack[0]}, 32'd0);
        chk("dato_clears", dato[0], 32'd0);

        // Byte-lane write through an aliased, unaligned address, then read back
        issue(0, 1'b1, 4'b0010, 32'h3800_1012, 32'h0000_AB00, 1'b1, 1'b1, 32'h0);
        wait_ack(0, "wr_byte1");
        issue(0, 1'b0, 4'h0, 32'h3800_0010, 32'h0, 1'b1, 1'b1, 32'hDEAD_ABEF);
        wait_ack(0, "rd_after_byte");

        // Abort in WAIT: cyc dropped at T+5, idle from T+6, no enable or ack
        issue(0, 1'b0, 4'h0, 32'h3800_0010, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (6) tick();
        chk("abort_busy_before", {31'd0, busy[0]}, 32'd1);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        tick();
        chk("abort_busy_after", {31'd0, busy[0]}, 32'd0);
        repeat (15) tick();
        issue(0, 1'b0, 4'h0, 32'h3800_0010, 32'h0, 1'b1, 1'b1, 32'hDEAD_ABEF);
        wait_ack(0, "rd_after_abort");

        // Reset at T+12 of a read: enable at T+11 still happens, ack never does
        issue(0, 1'b0, 4'h0, 32'h3800_0010, 32'h0, 1'b1, 1'b0, 32'h0);
        repeat (13) tick();
        rst[0] = 1'b1;
        tick();
        chk_idle(0, "midreset");
        rst[0] = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
        repeat (20) tick();
        chk("post_reset_busy", {31'd0, busy[0]}, 32'd0);

        // DUT1 (DELAYS=0): fill two words, then back-to-back reads
        issue(1, 1'b1, 4'hF, 32'h3800_001C, 32'h1234_5678, 1'b1, 1'b1, 32'h0);
        wait_ack(1, "d0_wr_word7");
        issue(1, 1'b1, 4'hF, 32'h3800_0008, 32'h0A0B_0C0D, 1'b1, 1'b1, 32'h0);
        wait_ack(1, "d0_wr_word2");
        issue(1, 1'b0, 4'h0, 32'h3800_001C, 32'h0, 1'b1, 1'b1, 32'h1234_5678);
        wait_ack(1, "d0_b2b_rd1");
        issue(1, 1'b0, 4'h0, 32'h3800_0008, 32'h0, 1'b1, 1'b1, 32'h0A0B_0C0D);
        wait_ack(1, "d0_b2b_rd2");

        // Abort in ACCESS: the write still lands, the ack is suppressed
        issue(1, 1'b1, 4'hF, 32'h3800_0008, 32'hA5A5_A5A5, 1'b1, 1'b0, 32'h0);
        repeat (2) tick();
        cyc[1] = 1'b0; stb[1] = 1'b0;
        repeat (6) tick();
        chk("late_abort_busy", {31'd0, busy[1]}, 32'd0);
        issue(1, 1'b0, 4'h0, 32'h3800_0008, 32'h0, 1'b1, 1'b1, 32'hA5A5_A5A5);
        wait_ack(1, "d0_rd_after_late_abort");

        repeat (5) tick();
        chk("queues_drained", 32'(en_q.size() + ack_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
